// File: rtl/unary_lane_decoder.sv
// Receive end of the unary product protocol: counts per-lane unary pulses back to
// binary, keeps a running frame total and presents the result on valid/ready.
module unary_lane_decoder #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_W     = 2 * WIDTH,
    parameter int unsigned SUM_W     = CNT_W + $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [NUM_LANES-1:0]       lane_en,
    input  logic [NUM_LANES-1:0]       lane_pulse,
    input  logic [NUM_LANES-1:0]       lane_done,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [NUM_LANES*CNT_W-1:0] result_count,
    output logic [SUM_W-1:0]           result_sum,
    output logic [NUM_LANES-1:0]       overflow,
    output logic                       busy
);

    localparam int unsigned INC_W = $clog2(NUM_LANES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q [NUM_LANES];
    logic [CNT_W-1:0]     count_d [NUM_LANES];
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [NUM_LANES-1:0] finished_q, finished_d;
    logic [NUM_LANES-1:0] overflow_q, overflow_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    logic [NUM_LANES-1:0] accept_c;
    logic [INC_W-1:0]     inc_c;
    logic                 load_frame_c;

    // A pulse is accepted only on a live lane whose counter still has headroom.
    always_comb begin
        accept_c = '0;
        inc_c    = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            accept_c[i] = ~finished_q[i] & lane_pulse[i] & (count_q[i] != CNT_MAX);
            inc_c       = inc_c + INC_W'(accept_c[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        finished_d   = finished_q;
        overflow_d   = overflow_q;
        load_frame_c = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            count_d[i] = count_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_frame_c = 1'b1;
                    state_d      = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (accept_c[i]) begin
                        count_d[i] = count_q[i] + CNT_W'(1);
                    end else if (~finished_q[i] & lane_pulse[i]) begin
                        overflow_d[i] = 1'b1;
                    end
                end
                sum_d      = sum_q + SUM_W'(inc_c);
                finished_d = finished_q | lane_done;
                if (&finished_d) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // valid is always high here, so ready alone completes the handshake
                if (result_ready) begin
                    if (start) begin
                        load_frame_c = 1'b1;
                        state_d      = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New frame: clear results and park masked lanes as already finished.
        if (load_frame_c) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                count_d[i] = '0;
            end
            sum_d      = '0;
            overflow_d = '0;
            finished_d = ~lane_en;
        end

        valid_d = (state_d == ST_OUT);
        busy_d  = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            finished_q <= '0;
            overflow_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            finished_q <= finished_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    always_comb begin
        result_count = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            result_count[i*CNT_W +: CNT_W] = count_q[i];
        end
    end

    assign result_sum   = sum_q;
    assign overflow     = overflow_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_unary_lane_decoder.sv
// Bench for unary_lane_decoder: default CNT_W=8 and a CNT_W=4 copy share stimulus;
// expected results come from per-lane pulse totals up to each lane's done cycle.
module tb_unary_lane_decoder;

    localparam int NL = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [NL-1:0]   lane_en;
    logic [NL-1:0]   lane_pulse;
    logic [NL-1:0]   lane_done;
    logic            result_ready;

    logic            v8, b8, v4, b4;
    logic [NL*8-1:0] c8;
    logic [NL*4-1:0] c4;
    logic [11:0]     s8;
    logic [7:0]      s4;
    logic [NL-1:0]   o8, o4;

    always #5 clk = ~clk;

    unary_lane_decoder #(.NUM_LANES(NL), .WIDTH(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .lane_en(lane_en),
        .lane_pulse(lane_pulse), .lane_done(lane_done), .result_valid(v8),
        .result_ready(result_ready), .result_count(c8), .result_sum(s8),
        .overflow(o8), .busy(b8)
    );

    unary_lane_decoder #(.NUM_LANES(NL), .WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .lane_en(lane_en),
        .lane_pulse(lane_pulse), .lane_done(lane_done), .result_valid(v4),
        .result_ready(result_ready), .result_count(c4), .result_sum(s4),
        .overflow(o4), .busy(b4)
    );

    int checks   = 0;
    int failures = 0;

    bit pb [NL][64];
    int done_at [NL];

    logic [NL*8-1:0] e_c8;
    logic [NL*4-1:0] e_c4;
    logic [11:0]     e_s8;
    logic [7:0]      e_s4;
    logic [NL-1:0]   e_o8, e_o4;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim;
        for (int i = 0; i < NL; i++) begin
            done_at[i] = 0;
            for (int c = 0; c < 64; c++) pb[i][c] = 1'b0;
        end
    endtask

    // Lane count = pulses seen through its done cycle, clipped at the counter max.
    task automatic compute_expected(input logic [NL-1:0] en);
        int n;
        int m8;
        int m4;
        e_c8 = '0; e_c4 = '0; e_o8 = '0; e_o4 = '0; e_s8 = '0; e_s4 = '0;
        for (int i = 0; i < NL; i++) begin
            if (en[i]) begin
                n = 0;
                for (int c = 0; c <= done_at[i]; c++) n += int'(pb[i][c]);
                m8 = (n > 255) ? 255 : n;
                m4 = (n > 15) ? 15 : n;
                e_c8[i*8 +: 8] = 8'(m8);
                e_c4[i*4 +: 4] = 4'(m4);
                e_o8[i] = (n > 255);
                e_o4[i] = (n > 15);
                e_s8 = e_s8 + 12'(m8);
                e_s4 = e_s4 + 8'(m4);
            end
        end
    endtask

    task automatic drive_random_lanes;
        lane_pulse = NL'($urandom);
        lane_done  = NL'($urandom);
    endtask

    // Start a frame (from IDLE, or as the OUT handshake cycle), stream it, then hold in OUT.
    task automatic do_frame(input string name, input logic [NL-1:0] en, input int hold,
                            input bit via_handshake);
        int last;
        last = 0;
        for (int i = 0; i < NL; i++) if (en[i] && done_at[i] > last) last = done_at[i];
        compute_expected(en);

        start = 1'b1; lane_en = en; result_ready = via_handshake;
        drive_random_lanes();
        tick();
        checks++;
        if (b8 !== 1'b1 || v8 !== 1'b0 || c8 !== '0 || s8 !== '0 || o8 !== '0 ||
            b4 !== 1'b1 || v4 !== 1'b0 || c4 !== '0 || s4 !== '0 || o4 !== '0) begin
            failures++;
            $display("FAIL %s start: busy=%0b/%0b valid=%0b/%0b sum=%0d/%0d ovf=%h/%h, required busy=1 valid=0 all cleared",
                     name, b8, b4, v8, v4, s8, s4, o8, o4);
        end

        for (int c = 0; c <= last; c++) begin
            start = 1'(($urandom));
            result_ready = 1'(($urandom));
            for (int i = 0; i < NL; i++) begin
                if (en[i]) begin
                    lane_pulse[i] = pb[i][c];
                    lane_done[i]  = (c >= done_at[i]);
                end else begin
                    lane_pulse[i] = 1'(($urandom));
                    lane_done[i]  = 1'(($urandom));
                end
            end
            tick();
            if (c < last) begin
                checks++;
                if (b8 !== 1'b1 || v8 !== 1'b0 || b4 !== 1'b1 || v4 !== 1'b0) begin
                    failures++;
                    $display("FAIL %s collect c=%0d: busy=%0b/%0b valid=%0b/%0b, required busy=1 valid=0",
                             name, c, b8, b4, v8, v4);
                end
            end
        end

        checks++;
        if (v8 !== 1'b1 || b8 !== 1'b0 || v4 !== 1'b1 || b4 !== 1'b0) begin
            failures++;
            $display("FAIL %s valid_latency: valid=%0b/%0b busy=%0b/%0b, required valid=1 busy=0 one cycle after last done",
                     name, v8, v4, b8, b4);
        end
        checks++;
        if (c8 !== e_c8 || s8 !== e_s8 || o8 !== e_o8) begin
            failures++;
            $display("FAIL %s result8: count=%h sum=%0d ovf=%h, required count=%h sum=%0d ovf=%h",
                     name, c8, s8, o8, e_c8, e_s8, e_o8);
        end
        checks++;
        if (c4 !== e_c4 || s4 !== e_s4 || o4 !== e_o4) begin
            failures++;
            $display("FAIL %s result4: count=%h sum=%0d ovf=%h, required count=%h sum=%0d ovf=%h",
                     name, c4, s4, o4, e_c4, e_s4, e_o4);
        end

        for (int k = 0; k < hold; k++) begin
            result_ready = 1'b0;
            start = 1'(($urandom));
            drive_random_lanes();
            tick();
            checks++;
            if (v8 !== 1'b1 || v4 !== 1'b1 || c8 !== e_c8 || s8 !== e_s8 || o8 !== e_o8 ||
                c4 !== e_c4 || s4 !== e_s4 || o4 !== e_o4) begin
                failures++;
                $display("FAIL %s hold k=%0d: valid=%0b/%0b sum=%0d/%0d ovf=%h/%h, required valid=1 sum=%0d/%0d ovf=%h/%h",
                         name, k, v8, v4, s8, s4, o8, o4, e_s8, e_s4, e_o8, e_o4);
            end
        end
        result_ready = 1'b0;
        start = 1'b0;
    endtask

    // Complete the handshake without a new frame; results must persist with valid low.
    task automatic release_frame(input string name);
        result_ready = 1'b1; start = 1'b0;
        drive_random_lanes();
        tick();
        result_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (v8 !== 1'b0 || b8 !== 1'b0 || v4 !== 1'b0 || b4 !== 1'b0 ||
                c8 !== e_c8 || s8 !== e_s8 || o8 !== e_o8 || c4 !== e_c4 || o4 !== e_o4) begin
                failures++;
                $display("FAIL %s release k=%0d: valid=%0b/%0b busy=%0b/%0b sum=%0d ovf=%h, required valid=0 busy=0 sum=%0d ovf=%h",
                         name, k, v8, v4, b8, b4, s8, o8, e_s8, e_o8);
            end
            drive_random_lanes();
            tick();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; lane_en = '0; lane_pulse = '0; lane_done = '0;
        result_ready = 1'b0;
        tick(); tick();
        checks++;
        if (v8 !== 1'b0 || b8 !== 1'b0 || c8 !== '0 || s8 !== '0 || o8 !== '0 ||
            v4 !== 1'b0 || b4 !== 1'b0 || c4 !== '0 || s4 !== '0 || o4 !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%0b busy=%0b sum=%0d ovf=%h, required all 0", v8, b8, s8, o8);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_lane;
        clear_stim();
        for (int c = 0; c < 12; c++) pb[0][c] = 1'b1;
        done_at[0] = 12;
        do_frame("single_lane", 16'h0001, 2, 1'b0);
        checks++;
        if (c8[7:0] !== 8'd12 || s8 !== 12'd12 || o8 !== '0) begin
            failures++;
            $display("FAIL single_lane_value: count0=%0d sum=%0d ovf=%h, required 12 12 0", c8[7:0], s8, o8);
        end
        release_frame("single_lane");
    endtask

    task automatic test_staggered;
        clear_stim();
        for (int i = 0; i < NL; i++) begin
            for (int c = 0; c < i; c++) pb[i][c] = 1'b1;
            for (int c = i + 1; c < 64; c++) pb[i][c] = 1'(($urandom));
            done_at[i] = i;
        end
        do_frame("staggered", 16'hFFFF, 1, 1'b0);
        checks++;
        if (s8 !== 12'd120 || c8[15*8 +: 8] !== 8'd15 || s4 !== 8'd120) begin
            failures++;
            $display("FAIL staggered_value: sum=%0d/%0d count15=%0d, required 120/120 15", s8, s4, c8[15*8 +: 8]);
        end
        release_frame("staggered");
    endtask

    task automatic test_saturation;
        clear_stim();
        for (int c = 0; c < 26; c++) pb[0][c] = 1'b1;
        done_at[0] = 19;
        done_at[1] = 25;
        do_frame("saturation", 16'h0003, 1, 1'b0);
        checks++;
        if (c4[3:0] !== 4'd15 || o4[0] !== 1'b1 || s4 !== 8'd15) begin
            failures++;
            $display("FAIL saturation4: count0=%0d ovf0=%0b sum=%0d, required 15 1 15", c4[3:0], o4[0], s4);
        end
        checks++;
        if (c8[7:0] !== 8'd20 || o8 !== '0 || s8 !== 12'd20) begin
            failures++;
            $display("FAIL saturation8: count0=%0d ovf=%h sum=%0d, required 20 0 20", c8[7:0], o8, s8);
        end
        release_frame("saturation");
    endtask

    task automatic test_masked;
        clear_stim();
        for (int i = 0; i < NL; i++) for (int c = 0; c < 64; c++) pb[i][c] = 1'(($urandom));
        do_frame("all_masked", '0, 1, 1'b0);
        checks++;
        if (s8 !== '0 || c8 !== '0) begin
            failures++;
            $display("FAIL all_masked_value: sum=%0d count=%h, required 0 0", s8, c8);
        end
        release_frame("all_masked");

        clear_stim();
        for (int c = 0; c < 64; c++) pb[1][c] = 1'b1;
        pb[0][1] = 1'b1; pb[2][4] = 1'b1; pb[2][5] = 1'b1;
        done_at[0] = 3; done_at[2] = 5;
        do_frame("masked_lane", 16'h0005, 0, 1'b0);
        checks++;
        if (c8[15:8] !== 8'd0 || s8 !== 12'd3) begin
            failures++;
            $display("FAIL masked_lane_value: count1=%0d sum=%0d, required 0 3", c8[15:8], s8);
        end
        release_frame("masked_lane");
    endtask

    task automatic test_back_to_back;
        clear_stim();
        for (int i = 0; i < NL; i++) begin
            done_at[i] = int'($urandom_range(0, 10));
            for (int c = 0; c < 64; c++) pb[i][c] = 1'(($urandom));
        end
        do_frame("b2b_first", 16'hA5C3, 5, 1'b0);
        clear_stim();
        for (int c = 0; c < 4; c++) pb[3][c] = 1'b1;
        done_at[3] = 4;
        do_frame("b2b_second", 16'h0008, 1, 1'b1);
        checks++;
        if (c8[3*8 +: 8] !== 8'd4 || s8 !== 12'd4) begin
            failures++;
            $display("FAIL b2b_value: count3=%0d sum=%0d, required 4 4", c8[3*8 +: 8], s8);
        end
        release_frame("b2b");
    endtask

    task automatic test_reset_mid;
        clear_stim();
        start = 1'b1; lane_en = 16'h0001; lane_pulse = '0; lane_done = '0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            lane_pulse = 16'h0001;
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (v8 !== 1'b0 || b8 !== 1'b0 || c8 !== '0 || s8 !== '0 || o8 !== '0 ||
            b4 !== 1'b0 || c4 !== '0 || s4 !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%0b valid=%0b sum=%0d count=%h, required all 0", b8, v8, s8, c8);
        end
        lane_pulse = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (b8 !== 1'b0 || v8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: busy=%0b valid=%0b, required 0 0", b8, v8);
        end
        for (int c = 0; c < 5; c++) pb[0][c] = 1'b1;
        done_at[0] = 6;
        do_frame("after_reset", 16'h0001, 0, 1'b0);
        checks++;
        if (c8[7:0] !== 8'd5 || s8 !== 12'd5) begin
            failures++;
            $display("FAIL after_reset_value: count0=%0d sum=%0d, required 5 5", c8[7:0], s8);
        end
        release_frame("after_reset");
    endtask

    task automatic test_random;
        logic [NL-1:0] en;
        int            density;
        bit            chain;
        chain = 1'b0;
        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(0, 5))
                0:       en = '0;
                1:       en = '1;
                default: en = NL'($urandom);
            endcase
            for (int i = 0; i < NL; i++) begin
                done_at[i] = int'($urandom_range(0, 30));
                density = int'($urandom_range(0, 3));
                for (int c = 0; c < 64; c++)
                    pb[i][c] = (density == 3) ? 1'b1 : ($urandom_range(0, 2) < density);
            end
            do_frame("random", en, int'($urandom_range(0, 3)), chain);
            chain = 1'(($urandom));
            if (!chain) release_frame("random");
        end
        if (chain) release_frame("random_end");
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_staggered();
        test_saturation();
        test_masked();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unary_lane_decoder.md
Name: unary_lane_decoder

Overview:
- Receive end of the unary product protocol: takes NUM_LANES unary pulse streams, each with a level-held done flag, from an array of product blocks.
- Counts accepted pulses per lane back into binary and keeps a running frame total.
- Presents the frame result on a valid/ready output handshake.
- Sits between the product-block array and downstream binary consumers (activation/requantize logic).

Parameters:
- NUM_LANES, 16, number of unary input lanes.
- WIDTH, 4, operand width of the producers.
- CNT_W, 2*WIDTH, per-lane counter width; max count 2^CNT_W-1.
- SUM_W, CNT_W+$clog2(NUM_LANES), width of frame total.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin new frame; honoured only in IDLE, or in OUT during the handshake cycle.
- lane_en  in  NUM_LANES  lane mask, sampled when start is accepted.
- lane_pulse  in  NUM_LANES  unary pulse per lane; 1 = one unit this cycle.
- lane_done  in  NUM_LANES  per-lane end-of-stream, level.
- result_valid  out  1  frame result available.
- result_ready  in  1  downstream accepts result.
- result_count  out  NUM_LANES x CNT_W  per-lane binary counts.
- result_sum  out  SUM_W  sum of result_count over all lanes.
- overflow  out  NUM_LANES  sticky per-lane saturation flag.
- busy  out  1  high in COLLECT.

Behaviour:
- Reset (async, any state): state=IDLE; counts, sum, finished mask, overflow, result_valid, busy all 0.
- States: IDLE, COLLECT, OUT. All outputs registered.
- IDLE:
  - start=1 -> COLLECT next cycle.
  - Same edge: clear counts/sum/overflow; finished[i] <= ~lane_en[i].
  - Pulses and dones in the start cycle are ignored.
- COLLECT (busy=1), per cycle, per lane i with finished[i]=0:
  - lane_pulse[i]=1 and count<max: count+1, and the pulse adds 1 to the sum.
  - lane_pulse[i]=1 and count==max: count holds, overflow[i] set, nothing added to sum.
  - lane_done[i]=1: finished[i] set. A pulse in the same cycle is still counted.
- COLLECT, global rules:
  - Lanes with finished[i]=1 ignore pulse and done entirely.
  - Sum update: running_sum += popcount of accepted pulses that cycle (saturation-gated); single adder-tree increment.
  - result_sum always equals the sum of result_count.
  - When (finished | done-this-cycle) is all-ones -> OUT next cycle. Counts and sum include that final cycle.
  - Latency: last lane_done at cycle N -> result_valid=1 at N+1.
  - All lanes masked: COLLECT lasts exactly one cycle, then OUT with zero counts.
  - start in COLLECT is ignored.
- OUT:
  - result_valid=1; result_count, result_sum and overflow stable until handshake.
  - result_ready=0: hold indefinitely, no change.
  - result_valid & result_ready: handshake completes. Next state is IDLE, or COLLECT if start=1 that cycle (back-to-back frame, clear and mask load as in IDLE).
  - result_valid drops the cycle after the handshake unless the next frame completes.
  - Count and overflow registers are cleared only by start; after a handshake they keep the last values while valid=0.
  - Lane inputs are ignored in OUT.
- Width rules:
  - Counters saturate; they never wrap.
  - SUM_W is wide enough that the sum cannot overflow.
  - Increment width: $clog2(NUM_LANES+1).

Test Plan:
- Single lane, lane_en=16'h0001: 12 consecutive pulses then done (3x4 producer) -> result_count[0]=12, result_sum=12, valid at done+1, overflow=0.
- All 16 lanes, lane i emits i pulses then done, with staggered dones -> count[i]=i, result_sum=120, valid exactly one cycle after the latest done.
- CNT_W=4 override, lane 0 sends 20 pulses -> count[0]=15, overflow[0]=1, result_sum=15. Pulse on the done cycle counted; pulses after done ignored.
- lane_en=0 at start -> valid two cycles after start, all counts 0, sum 0. Masked lane pulsing during a frame contributes 0.
- result_ready low 5 cycles in OUT with lane inputs toggling -> outputs unchanged. Ready plus start in the same cycle -> next cycle busy=1, valid=0, counts cleared.
- reset_n asserted mid-COLLECT after 7 pulses -> immediately state IDLE, all outputs 0. A new frame after release counts from 0.
